// File: rtl/emif_axi_mm_responder.sv
// Memory-side AXI-MM responder for one local-memory bank: INCR full-width bursts, one transaction in flight.
// Optional macro EMIF_RESP_RANGE_CHECK_EN: bursts addressing beyond the bank get SLVERR, writes dropped, rdata=0.
module emif_axi_mm_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 9,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [7:0]          awlen_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [7:0]          arlen_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

    state_e                  state_q;
    logic                    active_q;
    logic                    rdPrio_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DEPTH_LOG2-1:0]   idx_d;
    logic [7:0]              len_q;
    logic [8:0]              cnt_q;
    logic [8:0]              cnt_d;
    logic                    rangeErr_q;
    logic                    wlastErr_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [ID_W-1:0]         bid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [ID_W-1:0]         rid_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic awOutOfRange;
    logic arOutOfRange;
`ifdef EMIF_RESP_RANGE_CHECK_EN
    assign awOutOfRange = (awaddr_i >> (DEPTH_LOG2 + OFF)) != '0;
    assign arOutOfRange = (araddr_i >> (DEPTH_LOG2 + OFF)) != '0;
`else
    assign awOutOfRange = 1'b0;
    assign arOutOfRange = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, the upper bits) never select anything.
    logic unusedAddr;
    assign unusedAddr = ^{awaddr_i, araddr_i};

    // The priority pointer only moves when both channels contend in the same cycle.
    logic awGrant;
    logic arGrant;
    assign awGrant = active_q && (state_q == IDLE) && awvalid_i && !(arvalid_i && rdPrio_q);
    assign arGrant = active_q && (state_q == IDLE) && arvalid_i && !(awvalid_i && !rdPrio_q);

    logic wBeat;
    logic wFinal;
    logic wBad;
    logic rHs;
    logic rLoad;
    assign wBeat  = (state_q == WR_DATA) && wvalid_i && wready_q;
    assign wFinal = (cnt_q[7:0] == len_q);
    assign wBad   = (wlast_i != wFinal);
    assign rHs    = rvalid_q && rready_i;
    assign rLoad  = (state_q == RD_DATA) && (!rvalid_q || rready_i) && (cnt_q <= {1'b0, len_q});
    assign idx_d  = idx_q + DEPTH_LOG2'(1);
    assign cnt_d  = cnt_q + 9'd1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            active_q   <= 1'b0;
            rdPrio_q   <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rangeErr_q <= 1'b0;
            wlastErr_q <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            active_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (awGrant) begin
                        state_q    <= WR_DATA;
                        idx_q      <= awaddr_i[OFF +: DEPTH_LOG2];
                        len_q      <= awlen_i;
                        cnt_q      <= '0;
                        bid_q      <= awid_i;
                        rangeErr_q <= awOutOfRange;
                        wlastErr_q <= 1'b0;
                        wready_q   <= 1'b1;
                        if (arvalid_i) rdPrio_q <= 1'b1;
                    end else if (arGrant) begin
                        state_q    <= RD_DATA;
                        idx_q      <= araddr_i[OFF +: DEPTH_LOG2];
                        len_q      <= arlen_i;
                        cnt_q      <= '0;
                        rid_q      <= arid_i;
                        rangeErr_q <= arOutOfRange;
                        if (awvalid_i) rdPrio_q <= 1'b0;
                    end
                end
                WR_DATA: begin
                    if (wBeat) begin
                        idx_q <= idx_d;
                        cnt_q <= cnt_d;
                        if (wBad) wlastErr_q <= 1'b1;
                        if (wFinal) begin
                            state_q  <= WR_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (rangeErr_q || wlastErr_q || wBad) ? 2'b10 : 2'b00;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready_i) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (rLoad) begin
                        idx_q    <= idx_d;
                        cnt_q    <= cnt_d;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (cnt_q[7:0] == len_q);
                        rresp_q  <= rangeErr_q ? 2'b10 : 2'b00;
                    end else if (rHs) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM stays out of reset so it maps onto block memory; read data is loaded only when the output slot frees up.
    always_ff @(posedge clk_i) begin
        if (wBeat && !rangeErr_q) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) mem[idx_q][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rLoad) rdata_q <= rangeErr_q ? '0 : mem[idx_q];
    end

    assign awready_o = awGrant;
    assign arready_o = arGrant;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign bresp_o   = bresp_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;

endmodule

// File: tb/tb_emif_axi_mm_responder.sv
// Randomized bench for emif_axi_mm_responder against a word-array memory model.
// Honours EMIF_RESP_RANGE_CHECK_EN the same way the design does.
module tb_emif_axi_mm_responder;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int ID_W       = 9;
    localparam int DEPTH_LOG2 = 6;
    localparam int BYTES      = DATA_W / 8;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int SPAN       = DEPTH * BYTES;
`ifdef EMIF_RESP_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic              arvalid, arready, rvalid, rready, rlast;
    logic [ID_W-1:0]   awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [DATA_W-1:0] wdata, rdata;
    logic [BYTES-1:0]  wstrb;
    logic [1:0]        bresp, rresp;

    always #5 clk = ~clk;

    emif_axi_mm_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .awvalid_i(awvalid), .awready_o(awready), .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
        .arvalid_i(arvalid), .arready_o(arready), .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen),
        .rvalid_o(rvalid), .rready_i(rready), .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast)
    );

    logic [DATA_W-1:0] modelMem [DEPTH];
    logic [DATA_W-1:0] beatData [256];
    logic [BYTES-1:0]  beatStrb [256];
    bit                prioRead;
    int                assertCount = 0;
    int                failCount = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic bit outOfRange(input logic [ADDR_W-1:0] a);
        return RANGE_CHECK && (a >= SPAN);
    endfunction

    function automatic int wordOf(input logic [ADDR_W-1:0] a);
        return int'((a / BYTES) % DEPTH);
    endfunction

    // Reset is asserted while both address valids are high, so the readies really have to be suppressed.
    task automatic pulseReset();
        rst_n = 1'b0;
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        checkOutput("rstAwReady", awready, 0);
        checkOutput("rstArReady", arready, 0);
        checkOutput("rstWReady", wready, 0);
        checkOutput("rstBValid", bvalid, 0);
        checkOutput("rstRValid", rvalid, 0);
        checkOutput("rstRLast", rlast, 0);
        checkOutput("rstBResp", bresp, 0);
        checkOutput("rstRResp", rresp, 0);
        checkOutput("rstBId", bid, 0);
        checkOutput("rstRId", rid, 0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        prioRead = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulusWrite(input int id, input logic [ADDR_W-1:0] addr, input int len,
                                      input int wlastBeat, input bit gaps, input int abortAfter);
        bit err;
        int base;
        err  = outOfRange(addr) || (wlastBeat != len);
        base = wordOf(addr);
        awid = ID_W'(id); awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 64 && !awready; k++) @(negedge clk);
        checkOutput("awReady", awready, 1);
        if (!awready) begin awvalid = 1'b0; return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (b == abortAfter) begin
                wvalid = 1'b0;
                pulseReset();
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = beatData[b]; wstrb = beatStrb[b]; wlast = (b == wlastBeat);
            @(negedge clk);
            for (int k = 0; k < 64 && !wready; k++) @(negedge clk);
            checkOutput("wReady", wready, 1);
            if (!wready) begin wvalid = 1'b0; wlast = 1'b0; return; end
            @(posedge clk); #1;
            if (!outOfRange(addr)) begin
                for (int i = 0; i < BYTES; i++)
                    if (beatStrb[b][i]) modelMem[(base + b) % DEPTH][8*i +: 8] = beatData[b][8*i +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        checkOutput("bValid", bvalid, 1);
        checkOutput("bId", bid, id);
        checkOutput("bResp", bresp, err ? 2 : 0);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            checkOutput("bHold", bvalid, 1);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("bDrop", bvalid, 0);
    endtask

    // stall: 0 = rready always high, 1 = alternate starting low, 2 = random
    task automatic applyStimulusRead(input int id, input logic [ADDR_W-1:0] addr, input int len, input int stall);
        bit                err;
        bit                held;
        int                base, beat, cycles;
        logic [DATA_W-1:0] hData, expData;
        logic              hLast;
        logic [ID_W-1:0]   hId;
        logic [1:0]        hResp;
        err  = outOfRange(addr);
        base = wordOf(addr);
        arid = ID_W'(id); araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 64 && !arready; k++) @(negedge clk);
        checkOutput("arReady", arready, 1);
        if (!arready) begin arvalid = 1'b0; return; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("rLatency1", rvalid, 0);
        @(posedge clk); #1;
        checkOutput("rLatency2", rvalid, 1);
        beat = 0; cycles = 0; held = 1'b0;
        hData = '0; hLast = 1'b0; hId = '0; hResp = '0;
        while (beat <= len && cycles < 4000) begin
            case (stall)
                0:       rready = 1'b1;
                1:       rready = cycles[0];
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (held) begin
                checkOutput("rHoldValid", rvalid, 1);
                checkOutput("rHoldData", rdata, hData);
                checkOutput("rHoldLast", rlast, hLast);
                checkOutput("rHoldId", rid, hId);
                checkOutput("rHoldResp", rresp, hResp);
            end
            held = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    expData = err ? '0 : modelMem[(base + beat) % DEPTH];
                    checkOutput("rData", rdata, expData);
                    checkOutput("rLast", rlast, beat == len);
                    checkOutput("rId", rid, id);
                    checkOutput("rResp", rresp, err ? 2 : 0);
                    beat++;
                end else begin
                    held = 1'b1; hData = rdata; hLast = rlast; hId = rid; hResp = rresp;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        rready = 1'b0;
        checkOutput("rBeats", beat, len + 1);
        checkOutput("rDrop", rvalid, 0);
    endtask

    // Called just after an edge with both address valids driven; readies are combinational so no edge is consumed.
    task automatic checkArbitration(output bit readWins);
        #1;
        readWins = prioRead;
        checkOutput("arbAwReady", awready, !readWins);
        checkOutput("arbArReady", arready, readWins);
        prioRead = !readWins;
    endtask

    task automatic fillBeats(input int n, input bit randStrb);
        for (int i = 0; i < n; i++) begin
            beatData[i] = {$urandom, $urandom};
            beatStrb[i] = randStrb ? BYTES'($urandom) : '1;
        end
    endtask

    initial begin
        bit                readWins;
        int                rl, wl;
        logic [ADDR_W-1:0] ra;
        awvalid = 0; awid = '0; awaddr = '0; awlen = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
        arvalid = 0; arid = '0; araddr = '0; arlen = '0; rready = 0;
        prioRead = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulseReset();

        fillBeats(DEPTH, 1'b0);
        applyStimulusWrite(1, 0, DEPTH - 1, DEPTH - 1, 1'b0, -1);

        for (int b = 0; b < 4; b++) begin beatData[b] = DATA_W'(b + 1); beatStrb[b] = '1; end
        applyStimulusWrite(5, 'h40, 3, 3, 1'b0, -1);
        applyStimulusRead(7, 'h40, 3, 0);

        beatData[0] = '1; beatStrb[0] = '1;
        applyStimulusWrite(2, 'h100, 0, 0, 1'b0, -1);
        beatData[0] = DATA_W'('hAA); beatStrb[0] = BYTES'(1);
        applyStimulusWrite(3, 'h100, 0, 0, 1'b0, -1);
        applyStimulusRead(4, 'h100, 0, 0);

        for (int c = 0; c < 2; c++) begin
            fillBeats(3, 1'b0);
            awid = ID_W'(20 + c); awaddr = 'h180; awlen = 8'd2; awvalid = 1'b1;
            arid = ID_W'(30 + c); araddr = 'h180; arlen = 8'd2; arvalid = 1'b1;
            checkArbitration(readWins);
            if (readWins) begin
                applyStimulusRead(30 + c, 'h180, 2, 0);
                applyStimulusWrite(20 + c, 'h180, 2, 2, 1'b0, -1);
            end else begin
                applyStimulusWrite(20 + c, 'h180, 2, 2, 1'b0, -1);
                applyStimulusRead(30 + c, 'h180, 2, 0);
            end
        end

        fillBeats(4, 1'b0);
        applyStimulusWrite(6, 'h80, 3, 1, 1'b0, -1);
        fillBeats(4, 1'b0);
        applyStimulusWrite(6, 'h80, 3, -1, 1'b0, -1);
        applyStimulusRead(6, 'h80, 3, 0);

        applyStimulusRead(8, 'h0, 7, 1);

        applyStimulusRead(9, 32'h8000_0040, 1, 0);
        fillBeats(2, 1'b0);
        applyStimulusWrite(10, 32'h8000_0000, 1, 1, 1'b0, -1);
        applyStimulusRead(11, 'h0, 1, 0);

        for (int t = 0; t < 30; t++) begin
            rl = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = ADDR_W'(SPAN - 2 * BYTES);
                default: ra = ADDR_W'($urandom_range(0, SPAN - 1));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                fillBeats(rl + 1, 1'b1);
                wl = rl;
                if ($urandom_range(0, 5) == 0) wl = ($urandom_range(0, 1) == 1) ? -1 : 0;
                applyStimulusWrite(t, ra, rl, wl, 1'b1, -1);
            end else begin
                applyStimulusRead(t, ra, rl, int'($urandom_range(0, 2)));
            end
        end

        fillBeats(8, 1'b0);
        applyStimulusWrite(12, 'h20, 7, 7, 1'b0, 3);
        fillBeats(2, 1'b0);
        applyStimulusWrite(13, 'h28, 1, 1, 1'b0, -1);
        applyStimulusRead(14, 'h20, 7, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
